// File: rtl/store_buffer.sv
// ---------------------------------------------------------------------------
// store_buffer
//
// Write-side companion to the LW read path in the memory stage. SW stores
// from execute are queued in a small circular FIFO and drained to the
// 64-word data memory one word per handshake. A combinational lookup
// forwards the youngest queued store data to an in-flight LW, so loads
// never see stale memory behind a pending store.
//
// Ports:
//   mem_clk_x70      clock, rising edge
//   mem_rst_x70      asynchronous active-high reset
//   st_valid_x70     store request from execute
//   st_addr_x70      byte address of the store (word index = addr[7:2])
//   st_data_x70      store data
//   st_ready_x70     buffer can accept a store this cycle
//   misalign_x70     one-cycle pulse after accepting a store with addr[1:0] != 0
//   mem_wr_en_x70    write request to data memory
//   mem_wr_word_x70  word index of the entry being written
//   mem_wr_data_x70  data of the entry being written
//   mem_wr_ack_x70   memory accepted the current write
//   ld_addr_x70      byte address of an in-flight LW
//   ld_hit_x70       some queued entry matches ld_addr_x70[7:2]
//   ld_data_x70      data of the youngest matching entry, 0 on no hit
//   empty_x70        nothing queued and no write outstanding
// ---------------------------------------------------------------------------
module store_buffer #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic        mem_clk_x70,
    input  logic        mem_rst_x70,
    input  logic        st_valid_x70,
    input  logic [7:0]  st_addr_x70,
    input  logic [31:0] st_data_x70,
    output logic        st_ready_x70,
    output logic        misalign_x70,
    output logic        mem_wr_en_x70,
    output logic [5:0]  mem_wr_word_x70,
    output logic [31:0] mem_wr_data_x70,
    input  logic        mem_wr_ack_x70,
    input  logic [7:0]  ld_addr_x70,
    output logic        ld_hit_x70,
    output logic [31:0] ld_data_x70,
    output logic        empty_x70
);

    typedef enum logic {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } state_t;

    localparam logic [PTR_W:0] CNT_FULL = DEPTH[PTR_W:0];
    localparam logic [PTR_W:0] CNT_ZERO = '0;
    localparam logic [PTR_W:0] CNT_ONE  = (PTR_W+1)'(1);

    state_t state, state_next;

    logic [5:0]       word_q [DEPTH];
    logic [31:0]      data_q [DEPTH];
    logic [PTR_W-1:0] head, tail;
    logic [PTR_W:0]   count;

    logic             push, pop;
    logic             load;
    logic [PTR_W-1:0] load_idx;
    logic [PTR_W-1:0] fwd_idx;

    // The load address byte offset plays no part in a word-granular lookup.
    logic unused_ld_offset;
    assign unused_ld_offset = ^ld_addr_x70[1:0];

    // Ready looks only at registered count, so a full buffer refuses a
    // store even when a pop lands in the same cycle.
    assign st_ready_x70  = (count != CNT_FULL);
    assign push          = st_valid_x70 && st_ready_x70;
    assign pop           = (state == WRITE) && mem_wr_ack_x70;
    assign mem_wr_en_x70 = (state == WRITE);
    assign empty_x70     = (count == CNT_ZERO) && (state == IDLE);

    // Entry storage. Contents are meaningless outside the head..tail window,
    // so the array needs no reset.
    always_ff @(posedge mem_clk_x70) begin
        if (push) begin
            word_q[tail] <= st_addr_x70[7:2];
            data_q[tail] <= st_data_x70;
        end
    end

    // Pointers, occupancy and the misalign pulse.
    always_ff @(posedge mem_clk_x70 or posedge mem_rst_x70) begin
        if (mem_rst_x70) begin
            head         <= '0;
            tail         <= '0;
            count        <= '0;
            misalign_x70 <= 1'b0;
        end else begin
            if (push) begin
                tail <= tail + PTR_W'(1);
            end
            if (pop) begin
                head <= head + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
            misalign_x70 <= push && (st_addr_x70[1:0] != 2'b00);
        end
    end

    // Drain FSM state register.
    always_ff @(posedge mem_clk_x70 or posedge mem_rst_x70) begin
        if (mem_rst_x70) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Drain FSM next state. In WRITE an ack with more entries behind the
    // head preloads head+1 so consecutive writes run without a bubble.
    // The head entry stays counted until its ack, so count >= 1 in WRITE.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        load_idx   = head;
        case (state)
            IDLE: begin
                if (count != CNT_ZERO) begin
                    load       = 1'b1;
                    load_idx   = head;
                    state_next = WRITE;
                end
            end
            WRITE: begin
                if (mem_wr_ack_x70) begin
                    if (count != CNT_ONE) begin
                        load     = 1'b1;
                        load_idx = head + PTR_W'(1);
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Write port registers, held stable between loads.
    always_ff @(posedge mem_clk_x70 or posedge mem_rst_x70) begin
        if (mem_rst_x70) begin
            mem_wr_word_x70 <= '0;
            mem_wr_data_x70 <= '0;
        end else if (load) begin
            mem_wr_word_x70 <= word_q[load_idx];
            mem_wr_data_x70 <= data_q[load_idx];
        end
    end

    // Forwarding lookup. Entries are scanned oldest to youngest so the last
    // match wins. A store accepted this cycle is not yet in count and
    // therefore stays invisible until the next cycle.
    always_comb begin
        ld_hit_x70  = 1'b0;
        ld_data_x70 = '0;
        fwd_idx     = head;
        for (int i = 0; i < DEPTH; i++) begin
            fwd_idx = head + PTR_W'(i);
            if ((i < int'(count)) && (word_q[fwd_idx] == ld_addr_x70[7:2])) begin
                ld_hit_x70  = 1'b1;
                ld_data_x70 = data_q[fwd_idx];
            end
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// ---------------------------------------------------------------------------
// tb_store_buffer
//
// Self-checking bench for store_buffer. Every accepted store is pushed to a
// scoreboard queue as {addr[7:2], data}; every completed memory write pops
// the queue and is compared against it. Directed checks cover reset values,
// write latency, backpressure, back-to-back draining, forwarding, the
// misalign pulse and an asynchronous reset in the middle of a write.
// ---------------------------------------------------------------------------
module tb_store_buffer;

    typedef struct packed {
        logic [5:0]  word;
        logic [31:0] data;
    } sb_entry_t;

    logic        mem_clk_x70;
    logic        mem_rst_x70;
    logic        st_valid_x70;
    logic [7:0]  st_addr_x70;
    logic [31:0] st_data_x70;
    logic        st_ready_x70;
    logic        misalign_x70;
    logic        mem_wr_en_x70;
    logic [5:0]  mem_wr_word_x70;
    logic [31:0] mem_wr_data_x70;
    logic        mem_wr_ack_x70;
    logic [7:0]  ld_addr_x70;
    logic        ld_hit_x70;
    logic [31:0] ld_data_x70;
    logic        empty_x70;

    int          check_count = 0;
    int          fail_count  = 0;
    sb_entry_t   sb_queue[$];
    sb_entry_t   sb_exp;

    store_buffer #(.DEPTH(4), .PTR_W(2)) dut (
        .mem_clk_x70     (mem_clk_x70),
        .mem_rst_x70     (mem_rst_x70),
        .st_valid_x70    (st_valid_x70),
        .st_addr_x70     (st_addr_x70),
        .st_data_x70     (st_data_x70),
        .st_ready_x70    (st_ready_x70),
        .misalign_x70    (misalign_x70),
        .mem_wr_en_x70   (mem_wr_en_x70),
        .mem_wr_word_x70 (mem_wr_word_x70),
        .mem_wr_data_x70 (mem_wr_data_x70),
        .mem_wr_ack_x70  (mem_wr_ack_x70),
        .ld_addr_x70     (ld_addr_x70),
        .ld_hit_x70      (ld_hit_x70),
        .ld_data_x70     (ld_data_x70),
        .empty_x70       (empty_x70)
    );

    // Free-running clock, 10 time units per cycle.
    initial mem_clk_x70 = 1'b0;
    always #5 mem_clk_x70 = ~mem_clk_x70;

    // Hard stop in case something wedges outside the bounded waits.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, expected to finish", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        check_count++;
        if (observed !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t",
                     tag, observed, expected, $time);
        end
    endtask

    task automatic tick();
        @(posedge mem_clk_x70);
        #1;
    endtask

    // Present one store and hold it until accepted (bounded). Returns 1 time
    // unit after the accepting edge with st_valid_x70 dropped.
    task automatic applyStimulus(input logic [7:0] addr, input logic [31:0] data);
        int wait_cycles = 0;
        st_valid_x70 = 1'b1;
        st_addr_x70  = addr;
        st_data_x70  = data;
        @(negedge mem_clk_x70);
        while (!st_ready_x70 && wait_cycles < 50) begin
            @(negedge mem_clk_x70);
            wait_cycles++;
        end
        if (!st_ready_x70) begin
            checkOutput("push_timeout", 32'(st_ready_x70), 32'd1);
        end
        @(posedge mem_clk_x70);
        #1;
        st_valid_x70 = 1'b0;
    endtask

    // Wait (bounded) until the buffer has drained completely.
    task automatic waitDrain();
        int n = 0;
        while (!empty_x70 && n < 200) begin
            tick();
            n++;
        end
        checkOutput("drain_empty", 32'(empty_x70), 32'd1);
    endtask

    // Scoreboard monitor, sampled on the falling edge where all inputs are
    // stable. A write handshake pops and compares; an accepted store pushes.
    always @(negedge mem_clk_x70) begin
        if (!mem_rst_x70) begin
            if (mem_wr_en_x70 && mem_wr_ack_x70) begin
                if (sb_queue.size() == 0) begin
                    checkOutput("unexpected_write", 32'd1, 32'd0);
                end else begin
                    sb_exp = sb_queue.pop_front();
                    $display("[TB] pop  word=%0d data=%0d", mem_wr_word_x70, mem_wr_data_x70);
                    checkOutput("wr_word", 32'(mem_wr_word_x70), 32'(sb_exp.word));
                    checkOutput("wr_data", mem_wr_data_x70, sb_exp.data);
                end
            end
            if (st_valid_x70 && st_ready_x70) begin
                sb_queue.push_back('{word: st_addr_x70[7:2], data: st_data_x70});
                $display("[TB] push word=%0d data=%0d", st_addr_x70[7:2], st_data_x70);
            end
        end
    end

    initial begin
        int en_seen;

        mem_rst_x70    = 1'b1;
        st_valid_x70   = 1'b0;
        st_addr_x70    = '0;
        st_data_x70    = '0;
        mem_wr_ack_x70 = 1'b0;
        ld_addr_x70    = '0;

        // Reset values
        tick();
        checkOutput("rst_ready",    32'(st_ready_x70),   32'd1);
        checkOutput("rst_wr_en",    32'(mem_wr_en_x70),  32'd0);
        checkOutput("rst_wr_word",  32'(mem_wr_word_x70), 32'd0);
        checkOutput("rst_wr_data",  mem_wr_data_x70,     32'd0);
        checkOutput("rst_misalign", 32'(misalign_x70),   32'd0);
        checkOutput("rst_empty",    32'(empty_x70),      32'd1);
        checkOutput("rst_ld_hit",   32'(ld_hit_x70),     32'd0);
        tick();
        mem_rst_x70 = 1'b0;
        tick();

        // Single store, immediate ack
        $display("[TB] single store");
        mem_wr_ack_x70 = 1'b1;
        applyStimulus(8'h10, 32'd77);
        checkOutput("lat_edge1_en", 32'(mem_wr_en_x70), 32'd0);
        tick();
        checkOutput("lat_edge2_en",   32'(mem_wr_en_x70),   32'd1);
        checkOutput("lat_edge2_word", 32'(mem_wr_word_x70), 32'd4);
        checkOutput("lat_edge2_data", mem_wr_data_x70,      32'd77);
        tick();
        checkOutput("single_en_drop", 32'(mem_wr_en_x70), 32'd0);
        checkOutput("single_empty",   32'(empty_x70),     32'd1);

        // Fill and backpressure
        $display("[TB] fill and backpressure");
        mem_wr_ack_x70 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(8'(i * 4), 32'(i + 1));
        end
        checkOutput("full_ready", 32'(st_ready_x70), 32'd0);
        st_valid_x70 = 1'b1;
        st_addr_x70  = 8'h10;
        st_data_x70  = 32'd5;
        tick();
        tick();
        checkOutput("full_hold_ready", 32'(st_ready_x70),   32'd0);
        checkOutput("full_hold_en",    32'(mem_wr_en_x70),  32'd1);
        checkOutput("full_hold_word",  32'(mem_wr_word_x70), 32'd0);
        checkOutput("full_hold_data",  mem_wr_data_x70,      32'd1);
        mem_wr_ack_x70 = 1'b1;
        tick();
        checkOutput("b2b_word1",   32'(mem_wr_word_x70), 32'd1);
        checkOutput("b2b_en1",     32'(mem_wr_en_x70),   32'd1);
        checkOutput("ready_after_pop", 32'(st_ready_x70), 32'd1);
        tick();
        st_valid_x70 = 1'b0;
        checkOutput("b2b_word2", 32'(mem_wr_word_x70), 32'd2);
        checkOutput("b2b_en2",   32'(mem_wr_en_x70),   32'd1);
        tick();
        checkOutput("b2b_word3", 32'(mem_wr_word_x70), 32'd3);
        checkOutput("b2b_en3",   32'(mem_wr_en_x70),   32'd1);
        tick();
        checkOutput("b2b_word5th", 32'(mem_wr_word_x70), 32'd4);
        checkOutput("b2b_data5th", mem_wr_data_x70,      32'd5);
        tick();
        checkOutput("fill_done_en",    32'(mem_wr_en_x70), 32'd0);
        checkOutput("fill_done_empty", 32'(empty_x70),     32'd1);

        // Forwarding, youngest wins; same-cycle store is invisible
        $display("[TB] forwarding");
        mem_wr_ack_x70 = 1'b0;
        applyStimulus(8'h20, 32'd11);
        applyStimulus(8'h20, 32'd22);
        ld_addr_x70 = 8'h22;
        #1;
        checkOutput("fwd_hit",  32'(ld_hit_x70), 32'd1);
        checkOutput("fwd_data", ld_data_x70,     32'd22);
        ld_addr_x70 = 8'h24;
        #1;
        checkOutput("fwd_miss_hit",  32'(ld_hit_x70), 32'd0);
        checkOutput("fwd_miss_data", ld_data_x70,     32'd0);
        ld_addr_x70  = 8'h40;
        st_valid_x70 = 1'b1;
        st_addr_x70  = 8'h40;
        st_data_x70  = 32'd44;
        #1;
        checkOutput("fwd_same_cycle", 32'(ld_hit_x70), 32'd0);
        tick();
        st_valid_x70 = 1'b0;
        #1;
        checkOutput("fwd_next_hit",  32'(ld_hit_x70), 32'd1);
        checkOutput("fwd_next_data", ld_data_x70,     32'd44);
        ld_addr_x70 = 8'h21;
        #1;
        checkOutput("fwd_mid_data", ld_data_x70, 32'd22);
        mem_wr_ack_x70 = 1'b1;
        waitDrain();
        ld_addr_x70 = 8'h20;
        #1;
        checkOutput("fwd_after_drain", 32'(ld_hit_x70), 32'd0);

        // Streaming push+pop with pointer wrap
        $display("[TB] streaming push and pop");
        for (int i = 0; i < 6; i++) begin
            applyStimulus(8'(8'h80 + i * 4), 32'(100 + i));
            checkOutput("stream_ready", 32'(st_ready_x70), 32'd1);
            checkOutput("stream_busy",  32'(empty_x70),    32'd0);
        end
        waitDrain();

        // Misaligned store
        $display("[TB] misaligned store");
        applyStimulus(8'h13, 32'd9);
        checkOutput("misalign_pulse", 32'(misalign_x70), 32'd1);
        tick();
        checkOutput("misalign_clear", 32'(misalign_x70),    32'd0);
        checkOutput("misalign_word",  32'(mem_wr_word_x70), 32'd4);
        checkOutput("misalign_data",  mem_wr_data_x70,      32'd9);
        waitDrain();

        // Asynchronous reset in the middle of a write
        $display("[TB] reset mid-write");
        mem_wr_ack_x70 = 1'b0;
        applyStimulus(8'h50, 32'd201);
        applyStimulus(8'h54, 32'd202);
        applyStimulus(8'h58, 32'd203);
        tick();
        checkOutput("midrst_en_before", 32'(mem_wr_en_x70), 32'd1);
        #2;
        mem_rst_x70 = 1'b1;
        #1;
        checkOutput("midrst_en_drop", 32'(mem_wr_en_x70), 32'd0);
        checkOutput("midrst_empty",   32'(empty_x70),     32'd1);
        sb_queue.delete();
        tick();
        mem_rst_x70 = 1'b0;
        mem_wr_ack_x70 = 1'b1;
        #1;
        checkOutput("postrst_empty", 32'(empty_x70),    32'd1);
        checkOutput("postrst_ready", 32'(st_ready_x70), 32'd1);
        en_seen = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (mem_wr_en_x70) en_seen++;
        end
        checkOutput("postrst_no_write", 32'(en_seen), 32'd0);

        checkOutput("sb_leftover", 32'(sb_queue.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", check_count, fail_count);
        $finish;
    end

endmodule
